// File: rtl/hamming_decoder_if.sv
// Codeword-in / byte-out stream bundle for the (12,8) Hamming decoder.
// slave is the decoder's view, master is the producer/consumer side.
interface hamming_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [12:1] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [8:1]  out_data;
  logic [3:0]  out_syndrome;
  logic        out_corrected;
  logic        out_uncorrectable;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable
  );
endinterface

// File: rtl/hamming_decoder.sv
// (12,8) Hamming SEC decoder: stage 1 registers codeword + syndrome, stage 2
// registers corrected data + flags. Saturating corrected/uncorrectable counters.
module hamming_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + W'(1);
  end
endmodule

module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  hamming_decoder_if.slave   bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   corr_cnt,
  output logic [CNT_W-1:0]   uncorr_cnt
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [12:1] code;
    logic [3:0]  syn;
  } s1_t;

  typedef struct packed {
    logic [8:1] data;
    logic [3:0] syn;
    logic       corr;
    logic       uncorr;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic            s1_adv, s2_adv, out_hs;

  // Backpressure propagates combinationally so a full pipe still moves when drained.
  assign s2_adv     = ~vld_pipe[2] | bus.out_ready;
  assign s1_adv     = ~vld_pipe[1] | s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    s1_d.code   = bus.in_code;
    s1_d.syn[0] = ^{bus.in_code[1], bus.in_code[3], bus.in_code[5],
                    bus.in_code[7], bus.in_code[9], bus.in_code[11]};
    s1_d.syn[1] = ^{bus.in_code[2], bus.in_code[3], bus.in_code[6],
                    bus.in_code[7], bus.in_code[10], bus.in_code[11]};
    s1_d.syn[2] = ^{bus.in_code[4], bus.in_code[5], bus.in_code[6],
                    bus.in_code[7], bus.in_code[12]};
    s1_d.syn[3] = ^{bus.in_code[8], bus.in_code[9], bus.in_code[10],
                    bus.in_code[11], bus.in_code[12]};
  end

  // Syndrome 1..12 names the flipped position; 13..15 can't be a single error.
  logic [12:1] fixed;
  logic        in_range;

  always_comb begin
    in_range = (s1_q.syn != 4'd0) && (s1_q.syn <= 4'd12);
    for (int n = 1; n <= 12; n++)
      fixed[n] = s1_q.code[n] ^ (in_range && (s1_q.syn == 4'(n)));
    s2_d.data   = {fixed[12], fixed[11], fixed[10], fixed[9],
                   fixed[7], fixed[6], fixed[5], fixed[3]};
    s2_d.syn    = s1_q.syn;
    s2_d.corr   = in_range;
    s2_d.uncorr = s1_q.syn >= 4'd13;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  assign bus.out_valid         = vld_pipe[2];
  assign bus.out_data          = s2_q.data;
  assign bus.out_syndrome      = s2_q.syn;
  assign bus.out_corrected     = s2_q.corr;
  assign bus.out_uncorrectable = s2_q.uncorr;

  assign out_hs = vld_pipe[2] & bus.out_ready;

  logic [1:0]            ev;
  logic [1:0][CNT_W-1:0] cnts;

  assign ev[0] = out_hs & s2_q.corr;
  assign ev[1] = out_hs & s2_q.uncorr;

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    hamming_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (ev[g]),
      .cnt (cnts[g])
    );
  end

  assign corr_cnt   = cnts[0];
  assign uncorr_cnt = cnts[1];
endmodule

// File: tb/tb_hamming_decoder.sv
// Randomized + directed bench for hamming_decoder against a positional-XOR
// Hamming reference model and an in-order scoreboard.
module tb_hamming_decoder;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

  hamming_decoder_if bus ();

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int m_corr = 0, m_uncorr = 0;
  int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
  logic [12:1] exp_q[$];

  logic        held;
  logic [8:1]  h_data;
  logic [3:0]  h_syn;
  logic        h_corr, h_uncorr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Syndrome of a Hamming word is the XOR of the indices of its set bits.
  function automatic logic [3:0] ref_syn(input logic [12:1] x);
    logic [3:0] s = '0;
    for (int n = 1; n <= 12; n++) if (x[n]) s ^= 4'(n);
    return s;
  endfunction

  function automatic logic [8:1] ref_data(input logic [12:1] x);
    logic [3:0] s = ref_syn(x);
    logic [8:1] d;
    if (s >= 1 && s <= 12) x[s] = ~x[s];
    for (int i = 1; i <= 8; i++) d[i] = x[dpos[i-1]];
    return d;
  endfunction

  function automatic logic [12:1] ref_enc(input logic [8:1] d);
    logic [12:1] x = '0;
    logic [3:0]  s;
    for (int i = 1; i <= 8; i++) x[dpos[i-1]] = d[i];
    s = ref_syn(x);
    x[1] = s[0]; x[2] = s[1]; x[4] = s[2]; x[8] = s[3];
    return x;
  endfunction

  // Called at a negedge: drive, score the coming edge, advance to next negedge.
  task automatic cycle(input logic iv, input logic [12:1] code, input logic ordy,
                       input logic clr, output logic acc);
    logic [12:1] c;
    logic [3:0]  s;
    logic        ec, eu;
    bus.in_valid  = iv;
    bus.in_code   = code;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < 2) || ordy));
    acc = iv && bus.in_ready;
    if (acc) exp_q.push_back(code);
    ec = 1'b0; eu = 1'b0;
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(bus.out_valid), 32'd0);
      else begin
        c  = exp_q.pop_front();
        s  = ref_syn(c);
        ec = (s >= 1 && s <= 12);
        eu = (s >= 13);
        n_out++;
        check("out_data", 32'(bus.out_data), 32'(ref_data(c)));
        check("out_syn", 32'(bus.out_syndrome), 32'(s));
        check("out_corr", 32'(bus.out_corrected), 32'(ec));
        check("out_uncorr", 32'(bus.out_uncorrectable), 32'(eu));
      end
    end
    if (clr) begin
      m_corr = 0; m_uncorr = 0;
    end else begin
      if (ec && m_corr < MAXC) m_corr++;
      if (eu && m_uncorr < MAXC) m_uncorr++;
    end
    held = bus.out_valid && !ordy;
    h_data = bus.out_data; h_syn = bus.out_syndrome;
    h_corr = bus.out_corrected; h_uncorr = bus.out_uncorrectable;
    @(negedge clk);
    check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
    check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
    if (held) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_fields", {19'd0, bus.out_data, bus.out_syndrome, bus.out_corrected,
             bus.out_uncorrectable}, {19'd0, h_data, h_syn, h_corr, h_uncorr});
    end
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic dir(input logic [12:1] code, input logic [8:1] d, input logic [3:0] s,
                     input logic c, input logic u);
    logic a;
    cycle(1'b1, code, 1'b1, 1'b0, a);
    check("lat_n1_valid", 32'(bus.out_valid), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, a);
    check("lat_n2_valid", 32'(bus.out_valid), 32'd1);
    check("dir_data", 32'(bus.out_data), 32'(d));
    check("dir_syn", 32'(bus.out_syndrome), 32'(s));
    check("dir_flags", {30'd0, bus.out_corrected, bus.out_uncorrectable}, {30'd0, c, u});
    cycle(1'b0, '0, 1'b1, 1'b0, a);
  endtask

  function automatic logic [12:1] rand_word();
    logic [12:1] x = ref_enc(8'($urandom));
    int p, q;
    case ($urandom_range(0, 3))
      0: ;
      1, 2: begin p = $urandom_range(1, 12); x[p] = ~x[p]; end
      default: begin
        p = $urandom_range(1, 12);
        q = (p % 12) + 1;
        x[p] = ~x[p]; x[q] = ~x[q];
      end
    endcase
    return x;
  endfunction

  initial begin
    logic a;
    int k, n0;
    logic [12:1] words[8];
    rst = 1'b1; cnt_clr = 1'b0; held = 1'b0;
    bus.in_valid = 1'b0; bus.in_code = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_cnts", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
    @(negedge clk);

    dir(12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
    dir(12'hA07, 8'hA5, 4'd6, 1'b1, 1'b0);
    dir(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
    dir(12'hA26, 8'hA5, 4'd1, 1'b1, 1'b0);
    check("dir_corr_cnt", 32'(corr_cnt), 32'd2);
    check("dir_uncorr_cnt", 32'(uncorr_cnt), 32'd1);

    // Burst of 8 with a 3-cycle output stall.
    for (int i = 0; i < 8; i++) words[i] = rand_word();
    k = 0; n0 = n_out;
    for (int cyc = 0; cyc < 40 && (k < 8 || exp_q.size() > 0); cyc++) begin
      cycle(k < 8, words[k % 8], !(cyc >= 3 && cyc < 6), 1'b0, a);
      if (a) k++;
    end
    check("burst_count", 32'(n_out - n0), 32'd8);

    // Saturation, then clear coincident with a counted handshake.
    cycle(1'b0, '0, 1'b1, 1'b1, a);
    for (int i = 0; i < 5; i++) begin
      logic [12:1] w = ref_enc(8'($urandom));
      int p = dpos[$urandom_range(0, 7)];
      w[p] = ~w[p];
      cycle(1'b1, w, 1'b1, 1'b0, a);
    end
    drain();
    check("sat_corr_cnt", 32'(corr_cnt), 32'(MAXC));
    cycle(1'b1, 12'hA07, 1'b0, 1'b0, a);
    cycle(1'b0, '0, 1'b0, 1'b0, a);
    check("clr_pre_valid", 32'(bus.out_valid), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b1, a);
    check("clr_coincident", 32'(corr_cnt), 32'd0);

    // Random traffic with an asynchronous reset mid-stream.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_cnts", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
        exp_q.delete();
        m_corr = 0; m_uncorr = 0; held = 1'b0;
        @(negedge clk);
        rst = 1'b0;
      end
      cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0, a);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
